// File: rtl/des_key_verifier.sv
// DES key-search confirmation stage: odd-parity check, then two known-pair
// decryptions through one shared combinational DES core before a key is accepted.

module des_core (
  input  logic [63:0] key_i,
  input  logic [63:0] data_i,
  input  logic        encrypt_i,
  output logic [63:0] data_o
);
  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Bit i set: round i rotates the key halves by two instead of one.
  localparam logic [15:0] ROT2 = 16'b0111_1110_1111_1100;
  // S1..S8, 64 nibbles each in row-major order, S1 entry 0 in the top nibble.
  localparam logic [2047:0] SBOX = {
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  logic [47:0] ks [16];

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  six;
    for (int j = 0; j < 48; j++) x[47-j] = r[32-E_T[j]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      s[31-4*b -: 4] = SBOX[2047 - 4*(64*b + 16*32'({six[5], six[0]}) + 32'(six[4:1])) -: 4];
    end
    for (int j = 0; j < 32; j++) p[31-j] = s[32-P_T[j]];
    return p;
  endfunction

  // Key schedule: all sixteen round keys from the 64-bit parity-expanded key.
  always_comb begin
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    ks = '{default: '0};
    for (int j = 0; j < 56; j++) cd[55-j] = key_i[64-PC1_T[j]];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
      if (ROT2[i]) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) ks[i][47-j] = cd[56-PC2_T[j]];
    end
  end

  // Sixteen Feistel rounds; decryption walks the round keys in reverse.
  always_comb begin
    logic [63:0] ip;
    logic [63:0] pre;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] t;
    for (int j = 0; j < 64; j++) ip[63-j] = data_i[64-IP_T[j]];
    l = ip[63:32];
    r = ip[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ feistel(r, encrypt_i ? ks[i] : ks[15-i]);
      l = t;
    end
    pre = {r, l};
    data_o = '0;
    for (int j = 0; j < 64; j++) data_o[63-j] = pre[64-FP_T[j]];
  end
endmodule

module des_key_verifier #(
  parameter int unsigned REJ_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [63:0]      Key,
  input  logic [63:0]      plaintext1,
  input  logic [63:0]      ciphertext1,
  input  logic [63:0]      plaintext2,
  input  logic [63:0]      ciphertext2,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic [63:0]      verified_key,
  output logic [1:0]       last_reject,
  output logic [REJ_W-1:0] reject_count
);
  localparam logic [1:0] REJ_NONE   = 2'b00;
  localparam logic [1:0] REJ_PARITY = 2'b01;
  localparam logic [1:0] REJ_PAIR1  = 2'b10;
  localparam logic [1:0] REJ_PAIR2  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DEC1, S_CMP1, S_DEC2, S_CMP2, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      key_q, key_d;
  logic [63:0]      pt1_q, pt1_d, ct1_q, ct1_d;
  logic [63:0]      pt2_q, pt2_d, ct2_q, ct2_d;
  logic [63:0]      pt_q, pt_d;
  logic [63:0]      vkey_q, vkey_d;
  logic [1:0]       last_q, last_d;
  logic [REJ_W-1:0] rej_q, rej_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [63:0] des_in;
  logic [63:0] des_out;
  logic        parity_ok;
  logic [REJ_W-1:0] rej_inc;

  assign des_in = (state_q == S_DEC2) ? ct2_q : ct1_q;

  des_core u_des (
    .key_i     (key_q),
    .data_i    (des_in),
    .encrypt_i (1'b0),
    .data_o    (des_out)
  );

  always_comb begin
    parity_ok = 1'b1;
    for (int b = 0; b < 8; b++) parity_ok = parity_ok & (^key_q[8*b +: 8]);
  end

  assign rej_inc = (&rej_q) ? rej_q : rej_q + REJ_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      pt1_q   <= '0;
      ct1_q   <= '0;
      pt2_q   <= '0;
      ct2_q   <= '0;
      pt_q    <= '0;
      vkey_q  <= '0;
      last_q  <= REJ_NONE;
      rej_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      pt1_q   <= pt1_d;
      ct1_q   <= ct1_d;
      pt2_q   <= pt2_d;
      ct2_q   <= ct2_d;
      pt_q    <= pt_d;
      vkey_q  <= vkey_d;
      last_q  <= last_d;
      rej_q   <= rej_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    pt1_d   = pt1_q;
    ct1_d   = ct1_q;
    pt2_d   = pt2_q;
    ct2_d   = ct2_q;
    pt_d    = pt_q;
    vkey_d  = vkey_q;
    last_d  = last_q;
    rej_d   = rej_q;
    unique case (state_q)
      S_IDLE: begin
        if (key_valid && ready_q) begin
          key_d   = Key;
          pt1_d   = plaintext1;
          ct1_d   = ciphertext1;
          pt2_d   = plaintext2;
          ct2_d   = ciphertext2;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!parity_ok) begin
          rej_d   = rej_inc;
          last_d  = REJ_PARITY;
          state_d = S_IDLE;
        end else begin
          state_d = S_DEC1;
        end
      end
      S_DEC1: begin
        pt_d    = des_out;
        state_d = S_CMP1;
      end
      S_CMP1: begin
        if (pt_q != pt1_q) begin
          rej_d   = rej_inc;
          last_d  = REJ_PAIR1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DEC2;
        end
      end
      S_DEC2: begin
        pt_d    = des_out;
        state_d = S_CMP2;
      end
      S_CMP2: begin
        if (pt_q != pt2_q) begin
          rej_d   = rej_inc;
          last_d  = REJ_PAIR2;
          state_d = S_IDLE;
        end else begin
          vkey_d  = key_q;
          last_d  = REJ_NONE;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (clear) begin
          vkey_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status flags are registered copies of the decoded next state.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
  end

  assign key_ready    = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign verified_key = vkey_q;
  assign last_reject  = last_q;
  assign reject_count = rej_q;
endmodule

// File: tb/tb_des_key_verifier.sv
// Directed bench for des_key_verifier: vector table of candidate keys plus
// saturation, clear, mid-check reset and input-stability sequences.

module tb_des_key_verifier;
  localparam int unsigned REJ_W = 8;

  localparam int IP [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int EX [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int PP [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [2047:0] SB = {
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  localparam logic [63:0] GKEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] GP1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] GC1  = 64'h85E813540F0AB405;
  localparam logic [63:0] WKEY = 64'h0101010101010101;

  typedef struct {
    logic [63:0] key, p1, c1, p2, c2;
    logic [1:0]  rej;
    int          lat;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset, key_valid, clear;
  logic             key_ready, busy, done;
  logic [63:0]      Key, plaintext1, ciphertext1, plaintext2, ciphertext2;
  logic [63:0]      verified_key;
  logic [1:0]       last_reject;
  logic [REJ_W-1:0] reject_count;

  int checks = 0;
  int failures = 0;
  int unsigned exp_rej = 0;

  always #5 clk = ~clk;

  des_key_verifier #(.REJ_W(REJ_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .Key          (Key),
    .plaintext1   (plaintext1),
    .ciphertext1  (ciphertext1),
    .plaintext2   (plaintext2),
    .ciphertext2  (ciphertext2),
    .clear        (clear),
    .busy         (busy),
    .done         (done),
    .verified_key (verified_key),
    .last_reject  (last_reject),
    .reject_count (reject_count)
  );

  // Reference DES encryption with an on-the-fly key schedule.
  function automatic logic [63:0] ref_enc(input logic [63:0] k, input logic [63:0] p);
    logic [55:0] cd;
    logic [47:0] sk, x;
    logic [63:0] ip, pre, o;
    logic [31:0] l, r, s, f, nr;
    logic [5:0]  six;
    int          idx;
    for (int j = 0; j < 56; j++) cd[55-j] = k[64-PC1[j]];
    for (int j = 0; j < 64; j++) ip[63-j] = p[64-IP[j]];
    l = ip[63:32];
    r = ip[31:0];
    for (int rnd = 0; rnd < 16; rnd++) begin
      for (int n = 0; n < SH[rnd]; n++) cd = {cd[54:28], cd[55], cd[26:0], cd[27]};
      for (int j = 0; j < 48; j++) sk[47-j] = cd[56-PC2[j]];
      for (int j = 0; j < 48; j++) x[47-j] = r[32-EX[j]];
      x = x ^ sk;
      for (int b = 0; b < 8; b++) begin
        six = x[47-6*b -: 6];
        idx = 64*b + 32*int'(six[5]) + 16*int'(six[0]) + int'(six[4:1]);
        s[31-4*b -: 4] = SB[2047-4*idx -: 4];
      end
      for (int j = 0; j < 32; j++) f[31-j] = s[32-PP[j]];
      nr = l ^ f;
      l = r;
      r = nr;
    end
    pre = {r, l};
    for (int j = 0; j < 64; j++) o[63-j] = pre[64-FP[j]];
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v == (2**REJ_W) - 1) ? v : v + 1;
  endfunction

  task automatic offer(input logic [63:0] k, input logic [63:0] p1, input logic [63:0] c1,
                       input logic [63:0] p2, input logic [63:0] c2);
    check("ready_before_offer", 64'(key_ready), 64'd1);
    Key = k; plaintext1 = p1; ciphertext1 = c1; plaintext2 = p2; ciphertext2 = c2;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic [63:0] gc2, wc2;
    logic        saw_done;
    bit          pass;

    reset = 1'b0; key_valid = 1'b0; clear = 1'b0;
    Key = '0; plaintext1 = '0; ciphertext1 = '0; plaintext2 = '0; ciphertext2 = '0;
    step();
    step();
    check("rst_key_ready", 64'(key_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_verified_key", verified_key, 64'd0);
    check("rst_last_reject", 64'(last_reject), 64'd0);
    check("rst_reject_count", 64'(reject_count), 64'd0);
    reset = 1'b1;
    step();

    gc2 = ref_enc(GKEY, 64'd0);
    wc2 = ref_enc(WKEY, 64'd0);
    vecs.push_back('{GKEY, GP1, GC1, 64'd0, gc2, 2'b00, 5});
    vecs.push_back('{64'h133457799BBCDFF0, GP1, GC1, 64'd0, gc2, 2'b01, 1});
    vecs.push_back('{GKEY, GP1, GC1, 64'd0, gc2 ^ 64'd1, 2'b11, 5});
    vecs.push_back('{GKEY, GP1, GC1 ^ 64'd1, 64'd0, gc2, 2'b10, 3});
    vecs.push_back('{64'h123457799BBCDFF1, GP1, GC1, 64'd0, gc2, 2'b01, 1});
    vecs.push_back('{GKEY, GP1 ^ 64'd1, GC1, 64'd0, gc2, 2'b10, 3});
    vecs.push_back('{WKEY, 64'h8000000000000000, 64'h95F8A5E5DD31D900, 64'd0, wc2, 2'b00, 5});
    vecs.push_back('{GKEY, GP1, GC1, 64'd1, gc2, 2'b11, 5});
    vecs.push_back('{64'd0, GP1, GC1, 64'd0, gc2, 2'b01, 1});

    foreach (vecs[i]) begin
      v = vecs[i];
      offer(v.key, v.p1, v.c1, v.p2, v.c2);
      saw_done = 1'b0;
      for (int s = 1; s < v.lat; s++) begin
        step();
        if (done) saw_done = 1'b1;
      end
      check($sformatf("v%0d_busy_before", i), 64'(busy), 64'd1);
      step();
      pass = (v.rej == 2'b00);
      if (!pass) exp_rej = sat_inc(exp_rej);
      check($sformatf("v%0d_no_early_done", i), 64'(saw_done), 64'd0);
      check($sformatf("v%0d_done", i), 64'(done), 64'(pass));
      check($sformatf("v%0d_key_ready", i), 64'(key_ready), 64'(!pass));
      check($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
      check($sformatf("v%0d_last_reject", i), 64'(last_reject), 64'(v.rej));
      check($sformatf("v%0d_reject_count", i), 64'(reject_count), 64'(exp_rej));
      check($sformatf("v%0d_verified_key", i), verified_key, pass ? v.key : 64'd0);
      if (pass) begin
        step();
        check($sformatf("v%0d_done_holds", i), 64'(done), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check($sformatf("v%0d_clear_done", i), 64'(done), 64'd0);
        check($sformatf("v%0d_clear_ready", i), 64'(key_ready), 64'd1);
        check($sformatf("v%0d_clear_vkey", i), verified_key, 64'd0);
      end
    end

    // Input stability: garbage and a spurious key_valid while the check runs.
    offer(GKEY, GP1, GC1, 64'd0, gc2);
    Key = 64'hDEADBEEFDEADBEEF; plaintext1 = 64'hFFFF0000FFFF0000;
    ciphertext2 = 64'h0F0F0F0F0F0F0F0F; key_valid = 1'b1;
    for (int s = 0; s < 5; s++) step();
    check("stab_done", 64'(done), 64'd1);
    check("stab_vkey", verified_key, GKEY);
    check("stab_last_reject", 64'(last_reject), 64'd0);
    step();
    check("stab_no_accept_in_done", 64'(key_ready), 64'd0);
    key_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("stab_clear_ready", 64'(key_ready), 64'd1);

    // Saturation: 260 back-to-back parity rejects.
    for (int n = 0; n < 260; n++) begin
      offer(64'h133457799BBCDFF0, GP1, GC1, 64'd0, gc2);
      step();
      exp_rej = sat_inc(exp_rej);
    end
    check("sat_count", 64'(reject_count), 64'(exp_rej));
    check("sat_count_ff", 64'(reject_count), 64'hFF);
    check("sat_last_reject", 64'(last_reject), 64'd1);

    // Golden pass, then clear together with key_valid in DONE.
    offer(GKEY, GP1, GC1, 64'd0, gc2);
    for (int s = 0; s < 5; s++) step();
    check("satpass_done", 64'(done), 64'd1);
    check("satpass_vkey", verified_key, GKEY);
    clear = 1'b1; key_valid = 1'b1;
    step();
    clear = 1'b0; key_valid = 1'b0;
    check("clrv_done", 64'(done), 64'd0);
    check("clrv_ready", 64'(key_ready), 64'd1);
    check("clrv_busy", 64'(busy), 64'd0);
    check("clrv_vkey", verified_key, 64'd0);
    check("clrv_count", 64'(reject_count), 64'hFF);
    step();
    check("clrv_not_accepted", 64'(busy), 64'd0);

    // Reset while in DEC2 discards the candidate.
    offer(GKEY, GP1, GC1, 64'd0, gc2);
    for (int s = 0; s < 3; s++) step();
    check("midrst_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    step();
    exp_rej = 0;
    check("midrst_ready", 64'(key_ready), 64'd1);
    check("midrst_busy0", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_vkey", verified_key, 64'd0);
    check("midrst_last", 64'(last_reject), 64'd0);
    check("midrst_count", 64'(reject_count), 64'(exp_rej));
    reset = 1'b1;
    saw_done = 1'b0;
    for (int s = 0; s < 8; s++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    check("midrst_stays_idle", 64'(saw_done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
